// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU control sequencer: FSM states, instruction field codes,
// condition codes and datapath mux-select encodings.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        HALT    = 3'd5
    } state_e;

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_LDST   = 4'b0100;
    localparam logic [3:0] OP_BCOND  = 4'b1100;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4;
    localparam logic [3:0] COND_LS = 4'd5;
    localparam logic [3:0] COND_GT = 4'd6;
    localparam logic [3:0] COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8;
    localparam logic [3:0] COND_FC = 4'd9;
    localparam logic [3:0] COND_LO = 4'd10;
    localparam logic [3:0] COND_HS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GE = 4'd13;
    localparam logic [3:0] COND_UC = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam logic [1:0] PC_SEL_INC  = 2'd0;
    localparam logic [1:0] PC_SEL_DISP = 2'd1;
    localparam logic [1:0] PC_SEL_RTGT = 2'd2;

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_MEM  = 2'd1;
    localparam logic [1:0] WSEL_LINK = 2'd2;

endpackage

// File: rtl/cpu_control_fsm_cond_eval.sv
// Branch/jump condition evaluator: maps the 4-bit condition field and the
// PSR flags {N,L,F,Z,C} to a take decision.
module cond_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [4:0] psr_flags_i,
    output logic       take_o
);

    logic n, l, f, z, c;

    assign {n, l, f, z, c} = psr_flags_i;

    always_comb begin
        take_o = 1'b0;
        case (cond_i)
            COND_EQ: take_o = z;
            COND_NE: take_o = !z;
            COND_CS: take_o = c;
            COND_CC: take_o = !c;
            COND_HI: take_o = l;
            COND_LS: take_o = !l;
            COND_GT: take_o = n;
            COND_LE: take_o = !n;
            COND_FS: take_o = f;
            COND_FC: take_o = !f;
            COND_LO: take_o = !l && !z;
            COND_HS: take_o = l || z;
            COND_LT: take_o = !n && !z;
            COND_GE: take_o = n || z;
            COND_UC: take_o = 1'b1;
            COND_NV: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the 16-bit CPU datapath.
// Define MEM_TIMEOUT_EN to add the mem_ready wait timeout (fault + HALT).
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYC = 255
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instruction,
    input  logic [4:0]  psr_flags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic        alu_imm_sel,
    output logic        psr_we,
    output logic [2:0]  state,
    output logic        fault
);

    state_e     state_q, state_d;
    logic [3:0] opcode, cond, ext;
    logic       take, is_load, is_store, timeout, unused_ir;

    assign opcode    = instruction[15:12];
    assign cond      = instruction[11:8];
    assign ext       = instruction[7:4];
    assign unused_ir = ^instruction[3:0];
    assign is_load   = (opcode == OP_LDST) && (ext == EXT_LOAD);
    assign is_store  = (opcode == OP_LDST) && (ext == EXT_STOR);
    assign state     = state_q;

    cond_eval u_cond_eval (
        .cond_i      (cond),
        .psr_flags_i (psr_flags),
        .take_o      (take)
    );

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;
    logic       fault_q, stall;

    // Non-wait states clear the counter, so it is already zero on entry to FETCH/MEM.
    assign stall   = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
    assign wait_d  = stall ? wait_q + 8'd1 : '0;
    assign timeout = stall && (wait_q == 8'(TIMEOUT_CYC - 1));
    assign fault   = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
            if (timeout) fault_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign fault   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Outputs are gated by rst_n so an access in flight is dropped the moment reset asserts.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_SEL_INC;
        rf_we       = 1'b0;
        rf_wsel     = WSEL_ALU;
        alu_imm_sel = 1'b0;
        psr_we      = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: state_d = EXECUTE;
                EXECUTE: begin
                    state_d = FETCH;
                    case (opcode)
                        OP_RTYPE: begin
                            psr_we  = 1'b1;
                            state_d = WB;
                        end
                        OP_LDST: begin
                            case (ext)
                                EXT_LOAD, EXT_STOR: state_d = MEM;
                                EXT_JCOND: begin
                                    pc_we  = take;
                                    pc_sel = take ? PC_SEL_RTGT : PC_SEL_INC;
                                end
                                EXT_JAL: begin
                                    rf_we   = 1'b1;
                                    rf_wsel = WSEL_LINK;
                                    pc_we   = 1'b1;
                                    pc_sel  = PC_SEL_RTGT;
                                end
                                default: ;
                            endcase
                        end
                        OP_BCOND: begin
                            pc_we  = take;
                            pc_sel = take ? PC_SEL_DISP : PC_SEL_INC;
                        end
                        default: begin
                            alu_imm_sel = 1'b1;
                            psr_we      = 1'b1;
                            state_d     = WB;
                        end
                    endcase
                end
                MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = is_store;
                    if (mem_ready) state_d = is_store ? FETCH : WB;
                end
                WB: begin
                    rf_we   = 1'b1;
                    rf_wsel = is_load ? WSEL_MEM : WSEL_ALU;
                    state_d = FETCH;
                end
                HALT:    state_d = HALT;
                default: state_d = FETCH;
            endcase
            if (timeout) state_d = HALT;
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: per-cycle expected control vectors for each
// instruction class, reset behaviour and (with MEM_TIMEOUT_EN) the timeout fault.
module tb_cpu_control_fsm;

    logic        clk, rst_n, mem_ready;
    logic [15:0] instruction;
    logic [4:0]  psr_flags;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, alu_imm_sel, psr_we, fault;
    logic [1:0]  pc_sel, rf_wsel;
    logic [2:0]  state;
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

    logic [15:0] V_RST, V_FGO, V_FWAIT, V_DEC, V_EX0, V_EXR, V_EXI, V_WBA, V_WBM;
    logic [15:0] V_MLD, V_MST, V_BR, V_JMP, V_JAL, V_HALT;

`ifdef MEM_TIMEOUT_EN
    cpu_control_fsm #(.TIMEOUT_CYC(4)) dut (
`else
    cpu_control_fsm dut (
`endif
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .psr_flags   (psr_flags),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .rf_we       (rf_we),
        .rf_wsel     (rf_wsel),
        .alu_imm_sel (alu_imm_sel),
        .psr_we      (psr_we),
        .state       (state),
        .fault       (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ex(input logic [2:0] st, input logic mreq, input logic mwe,
                                       input logic asel, input logic irwe, input logic pcwe,
                                       input logic [1:0] psel, input logic rfwe, input logic [1:0] wsel,
                                       input logic imm, input logic psrwe, input logic flt);
        return {mreq, mwe, asel, irwe, pcwe, psel, rfwe, wsel, imm, psrwe, st, flt};
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        #1;
        obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, rf_wsel,
               alu_imm_sel, psr_we, state, fault};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FETCH (ready) -> DECODE -> EXECUTE; returns one cycle after the EXECUTE edge.
    task automatic run_short(input string tag, input logic [15:0] ins, input logic [4:0] fl,
                             input logic [15:0] exp_ex);
        instruction = ins;
        psr_flags   = fl;
        mem_ready   = 1'b1;
        check({tag, "_fetch"}, V_FGO);
        tick();
        check({tag, "_decode"}, V_DEC);
        tick();
        check({tag, "_exec"}, exp_ex);
        tick();
    endtask

    initial begin
        //          st   req we  as  ir  pcw sel   rfw wsel  imm psr flt
        V_RST   = ex(S_F, 0,  0,  0,  0,  0,  2'd0, 0,  2'd0, 0,  0,  0);
        V_FGO   = ex(S_F, 1,  0,  0,  1,  1,  2'd0, 0,  2'd0, 0,  0,  0);
        V_FWAIT = ex(S_F, 1,  0,  0,  0,  0,  2'd0, 0,  2'd0, 0,  0,  0);
        V_DEC   = ex(S_D, 0,  0,  0,  0,  0,  2'd0, 0,  2'd0, 0,  0,  0);
        V_EX0   = ex(S_E, 0,  0,  0,  0,  0,  2'd0, 0,  2'd0, 0,  0,  0);
        V_EXR   = ex(S_E, 0,  0,  0,  0,  0,  2'd0, 0,  2'd0, 0,  1,  0);
        V_EXI   = ex(S_E, 0,  0,  0,  0,  0,  2'd0, 0,  2'd0, 1,  1,  0);
        V_WBA   = ex(S_W, 0,  0,  0,  0,  0,  2'd0, 1,  2'd0, 0,  0,  0);
        V_WBM   = ex(S_W, 0,  0,  0,  0,  0,  2'd0, 1,  2'd1, 0,  0,  0);
        V_MLD   = ex(S_M, 1,  0,  1,  0,  0,  2'd0, 0,  2'd0, 0,  0,  0);
        V_MST   = ex(S_M, 1,  1,  1,  0,  0,  2'd0, 0,  2'd0, 0,  0,  0);
        V_BR    = ex(S_E, 0,  0,  0,  0,  1,  2'd1, 0,  2'd0, 0,  0,  0);
        V_JMP   = ex(S_E, 0,  0,  0,  0,  1,  2'd2, 0,  2'd0, 0,  0,  0);
        V_JAL   = ex(S_E, 0,  0,  0,  0,  1,  2'd2, 1,  2'd2, 0,  0,  0);
        V_HALT  = ex(S_H, 0,  0,  0,  0,  0,  2'd0, 0,  2'd0, 0,  0,  1);

        rst_n = 1'b1; mem_ready = 1'b0; instruction = '0; psr_flags = '0;
        #2 rst_n = 1'b0;
        check("reset", V_RST);
        tick();
        check("reset_hold", V_RST);
        rst_n = 1'b1;
        check("fetch_idle", V_FWAIT);

        // ALU ops: 4 cycles each
        run_short("add", 16'h0152, 5'b00000, V_EXR);
        check("add_wb", V_WBA);
        tick();
        run_short("addi", 16'h5105, 5'b00000, V_EXI);
        check("addi_wb", V_WBA);
        tick();

        // Load with 3 stalled MEM cycles: 8 cycles total
        run_short("load", 16'h4102, 5'b00000, V_EX0);
        mem_ready = 1'b0;
        check("load_mem_w1", V_MLD);
        tick();
        check("load_mem_w2", V_MLD);
        tick();
        check("load_mem_w3", V_MLD);
        tick();
        mem_ready = 1'b1;
        check("load_mem_go", V_MLD);
        tick();
        check("load_wb", V_WBM);
        tick();

        run_short("store", 16'h4143, 5'b00000, V_EX0);
        check("store_mem", V_MST);
        tick();
        check("store_back", V_FGO);

        // Branches: flags {N,L,F,Z,C}
        run_short("beq_t", 16'hC005, 5'b00010, V_BR);
        check("beq_t_next", V_FGO);
        run_short("beq_n", 16'hC005, 5'b00000, V_EX0);
        check("beq_n_next", V_FGO);
        run_short("blo_t", 16'hCA00, 5'b00000, V_BR);
        run_short("blo_n", 16'hCA00, 5'b01000, V_EX0);
        run_short("bge_t", 16'hCD00, 5'b10000, V_BR);
        run_short("bhi_n", 16'hC400, 5'b00000, V_EX0);

        run_short("jal", 16'h4A83, 5'b00000, V_JAL);
        check("jal_next", V_FGO);
        run_short("jnv", 16'h4FC0, 5'b11111, V_EX0);
        run_short("juc", 16'h4EC0, 5'b00000, V_JMP);
        run_short("nop", 16'h4010, 5'b00000, V_EX0);
        check("nop_next", V_FGO);

        // Reset asserted while a store is stalled in MEM
        run_short("rst_st", 16'h4143, 5'b00000, V_EX0);
        mem_ready = 1'b0;
        check("rst_mem_stall", V_MST);
        rst_n = 1'b0;
        check("rst_mid_mem", V_RST);
        tick();
        check("rst_mid_hold", V_RST);
        rst_n = 1'b1;
        check("rst_release", V_FWAIT);

`ifdef MEM_TIMEOUT_EN
        tick();
        check("to_wait2", V_FWAIT);
        tick();
        check("to_wait3", V_FWAIT);
        tick();
        check("to_wait4", V_FWAIT);
        tick();
        check("to_halt", V_HALT);
        mem_ready = 1'b1;
        tick();
        check("to_halt_sticky", V_HALT);
        rst_n = 1'b0;
        check("to_reset_clears", V_RST);
        tick();
        rst_n = 1'b1;
        check("to_refetch", V_FGO);
`else
        for (int i = 0; i < 6; i++) begin
            tick();
            check("fetch_wait_forever", V_FWAIT);
        end
        mem_ready = 1'b1;
        check("fetch_late_ready", V_FGO);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
